// File: rtl/frame_packer.sv
// Folds a row-major 64x32 RGB pixel stream into {upper, lower} 48-bit frame RAM words.
// Optional FRAME_PACKER_GAMMA_EN squares each channel (c*c >> 8) in an extra pipeline stage.
module frame_packer #(
    parameter int unsigned PIXEL_DEPTH = 8,
    parameter int unsigned IMG_WIDTH   = 64,
    parameter int unsigned IMG_HEIGHT  = 32,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned NUM_SLOTS   = 12
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [3*PIXEL_DEPTH-1:0]   s_data,
    input  logic                       s_sof,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [6*PIXEL_DEPTH-1:0]   wr_data,
    output logic [1:0]                 wr_be,
    output logic                       frame_done,
    output logic                       sof_err
);

    localparam int unsigned PixW     = 3 * PIXEL_DEPTH;
    localparam logic [5:0]  ColLast  = 6'(IMG_WIDTH - 1);
    localparam logic [4:0]  RowLast  = 5'(IMG_HEIGHT - 1);
    localparam logic [3:0]  SlotLast = 4'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;
    logic [5:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [3:0] slot_q, slot_d;

    logic       accept;
    logic       wr_go;
    logic       last_beat;
    logic       resync;
    logic [4:0] w_row;
    logic [5:0] w_col;

    // Write-stage registers (one cycle after acceptance)
    logic                  p_en_q, p_en_d;
    logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
    logic [PixW-1:0]       p_pix_q, p_pix_d;
    logic [1:0]            p_be_q, p_be_d;
    logic                  p_done_q, p_done_d;
    logic                  p_err_q, p_err_d;

    assign s_ready = (state_q != StDone);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        slot_d    = slot_q;
        wr_go     = 1'b0;
        last_beat = 1'b0;
        resync    = 1'b0;
        w_row     = row_q;
        w_col     = col_q;
        unique case (state_q)
            StIdle: begin
                // Beats arriving before a start-of-frame are dropped
                if (accept && s_sof) begin
                    wr_go   = 1'b1;
                    w_row   = '0;
                    w_col   = '0;
                    col_d   = 6'd1;
                    row_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    wr_go = 1'b1;
                    if (s_sof) begin
                        resync = 1'b1;
                        w_row  = '0;
                        w_col  = '0;
                        col_d  = 6'd1;
                        row_d  = '0;
                    end else if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            last_beat = 1'b1;
                            row_d     = '0;
                            state_d   = StDone;
                        end else begin
                            row_d = row_q + 5'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            StDone: begin
                slot_d  = (slot_q == SlotLast) ? 4'd0 : slot_q + 4'd1;
                col_d   = '0;
                row_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        p_en_d   = wr_go;
        p_addr_d = p_addr_q;
        p_pix_d  = p_pix_q;
        p_be_d   = 2'b00;
        p_done_d = last_beat;
        p_err_d  = resync;
        if (wr_go) begin
            // Upper and lower halves share a row field; row[4] picks the byte-lane half
            p_addr_d = ADDR_WIDTH'({slot_q, 1'b0, w_row[3:0], w_col});
            p_pix_d  = s_data;
            p_be_d   = w_row[4] ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            slot_q   <= '0;
            p_en_q   <= 1'b0;
            p_addr_q <= '0;
            p_pix_q  <= '0;
            p_be_q   <= 2'b00;
            p_done_q <= 1'b0;
            p_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            slot_q   <= slot_d;
            p_en_q   <= p_en_d;
            p_addr_q <= p_addr_d;
            p_pix_q  <= p_pix_d;
            p_be_q   <= p_be_d;
            p_done_q <= p_done_d;
            p_err_q  <= p_err_d;
        end
    end

`ifdef FRAME_PACKER_GAMMA_EN
    function automatic logic [PixW-1:0] gamma(input logic [PixW-1:0] p);
        logic [2*PIXEL_DEPTH-1:0] sq;
        gamma = '0;
        for (int c = 0; c < 3; c++) begin
            sq = p[c*PIXEL_DEPTH +: PIXEL_DEPTH] * p[c*PIXEL_DEPTH +: PIXEL_DEPTH];
            gamma[c*PIXEL_DEPTH +: PIXEL_DEPTH] = sq[2*PIXEL_DEPTH-1 -: PIXEL_DEPTH];
        end
    endfunction

    logic                  g_en_q, g_en_d;
    logic [ADDR_WIDTH-1:0] g_addr_q, g_addr_d;
    logic [PixW-1:0]       g_pix_q, g_pix_d;
    logic [1:0]            g_be_q, g_be_d;
    logic                  g_done_q, g_done_d;
    logic                  g_err_q, g_err_d;

    always_comb begin
        g_en_d   = p_en_q;
        g_be_d   = p_be_q;
        g_done_d = p_done_q;
        g_err_d  = p_err_q;
        g_addr_d = g_addr_q;
        g_pix_d  = g_pix_q;
        if (p_en_q) begin
            g_addr_d = p_addr_q;
            g_pix_d  = gamma(p_pix_q);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            g_en_q   <= 1'b0;
            g_addr_q <= '0;
            g_pix_q  <= '0;
            g_be_q   <= 2'b00;
            g_done_q <= 1'b0;
            g_err_q  <= 1'b0;
        end else begin
            g_en_q   <= g_en_d;
            g_addr_q <= g_addr_d;
            g_pix_q  <= g_pix_d;
            g_be_q   <= g_be_d;
            g_done_q <= g_done_d;
            g_err_q  <= g_err_d;
        end
    end

    always_comb begin
        wr_en      = g_en_q;
        wr_addr    = g_addr_q;
        wr_data    = {g_pix_q, g_pix_q};
        wr_be      = g_be_q;
        frame_done = g_done_q;
        sof_err    = g_err_q;
    end
`else
    always_comb begin
        wr_en      = p_en_q;
        wr_addr    = p_addr_q;
        wr_data    = {p_pix_q, p_pix_q};
        wr_be      = p_be_q;
        frame_done = p_done_q;
        sof_err    = p_err_q;
    end
`endif

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: reset, full frames, slot wrap, resync, discard/stall, gamma.
module tb_frame_packer;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [47:0] wr_data;
    logic [1:0]  wr_be;
    logic        frame_done;
    logic        sof_err;

    int tests = 0;
    int fails = 0;
    int cur_beat = 0;

    logic [14:0] a0, a1024, a2047;
    logic [1:0]  b0, b1024, b2047;
    logic        d2047;

    frame_packer dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (beat %0d): observed %0h expected %0h", tag, cur_beat, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one beat; s_ready must already be high so it transfers at the next edge
    task automatic push(input logic [23:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        chk("ready_before_beat", 64'(s_ready), 64'd1);
        tick();
    endtask

    task automatic chk_write(input logic [3:0] slot, input logic [10:0] idx,
                             input logic [23:0] pix, input logic done, input logic err);
        logic [4:0] row;
        logic [5:0] col;
        row = idx[10:6];
        col = idx[5:0];
        chk("wr_en", 64'(wr_en), 64'd1);
        chk("wr_addr", 64'(wr_addr), 64'({slot, 1'b0, row[3:0], col}));
        chk("wr_be", 64'(wr_be), row[4] ? 64'd1 : 64'd2);
        chk("wr_data", 64'(wr_data), 64'({pix, pix}));
        chk("frame_done", 64'(frame_done), 64'(done));
        chk("sof_err", 64'(sof_err), 64'(err));
    endtask

    task automatic end_frame();
        chk("ready_low_in_done", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        tick();
        chk("ready_back_high", 64'(s_ready), 64'd1);
        chk("bubble_no_write", 64'(wr_en), 64'd0);
    endtask

    task automatic run_frame(input logic [3:0] slot, input bit gaps);
        for (int i = 0; i < 2048; i++) begin
            cur_beat = i;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                tick();
                chk("gap_no_write", 64'(wr_en), 64'd0);
            end
            push(24'(i), i == 0);
            chk_write(slot, 11'(i), 24'(i), i == 2047, 1'b0);
            if (i == 0) begin
                a0 = wr_addr;
                b0 = wr_be;
            end else if (i == 1024) begin
                a1024 = wr_addr;
                b1024 = wr_be;
            end else if (i == 2047) begin
                a2047 = wr_addr;
                b2047 = wr_be;
                d2047 = frame_done;
            end
        end
        end_frame();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_wr_be"}, 64'(wr_be), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_sof_err"}, 64'(sof_err), 64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1 chk_reset_outputs("rst_async");
        tick();
        rst = 1'b1;
        chk_reset_outputs("rst_release");

`ifdef FRAME_PACKER_GAMMA_EN
        push(24'hFF8000, 1'b1);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("gamma_not_yet", 64'(wr_en), 64'd0);
        tick();
        chk("gamma_wr_en", 64'(wr_en), 64'd1);
        chk("gamma_upper", 64'(wr_data[47:24]), 64'hFE4000);
        chk("gamma_lower", 64'(wr_data[23:0]), 64'hFE4000);
        chk("gamma_addr", 64'(wr_addr), 64'd0);
        chk("gamma_be", 64'(wr_be), 64'd2);
        push(24'h00FF80, 1'b0);
        s_valid = 1'b0;
        tick();
        chk("gamma2_upper", 64'(wr_data[47:24]), 64'h00FE40);
        chk("gamma2_addr", 64'(wr_addr), 64'd1);
        tick();
        chk("gamma_idle_no_write", 64'(wr_en), 64'd0);
`else
        // Full frame with pixel = index into slot 0
        run_frame(4'd0, 1'b0);
        chk("beat0_addr", 64'(a0), 64'h0000);
        chk("beat0_be", 64'(b0), 64'b10);
        chk("beat1024_addr", 64'(a1024), 64'h0000);
        chk("beat1024_be", 64'(b1024), 64'b01);
        chk("beat2047_addr", 64'(a2047), 64'h03FF);
        chk("beat2047_be", 64'(b2047), 64'b01);
        chk("beat2047_done", 64'(d2047), 64'd1);

        // Beats without start-of-frame in IDLE are discarded
        for (int i = 0; i < 5; i++) begin
            cur_beat = i;
            push(24'h111111 * 24'(i + 1), 1'b0);
            chk("discard_no_write", 64'(wr_en), 64'd0);
        end

        // Frame with random valid gaps lands contiguously in slot 1
        run_frame(4'd1, 1'b1);

        // Mid-frame resync in slot 2
        for (int i = 0; i < 300; i++) begin
            cur_beat = i;
            push(24'(i), i == 0);
            chk_write(4'd2, 11'(i), 24'(i), 1'b0, 1'b0);
        end
        cur_beat = 300;
        push(24'hABCDEF, 1'b1);
        chk_write(4'd2, 11'd0, 24'hABCDEF, 1'b0, 1'b1);
        chk("resync_addr", 64'(wr_addr), 64'h1000);
        for (int i = 1; i < 2048; i++) begin
            cur_beat = 300 + i;
            push(24'h300000 + 24'(i), 1'b0);
            chk_write(4'd2, 11'(i), 24'h300000 + 24'(i), i == 2047, 1'b0);
        end
        end_frame();

        // Reset mid-frame in slot 3 drops everything and returns to slot 0
        for (int i = 0; i < 100; i++) begin
            cur_beat = i;
            push(24'hC00000 + 24'(i), i == 0);
            chk_write(4'd3, 11'(i), 24'hC00000 + 24'(i), 1'b0, 1'b0);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        #3 rst = 1'b0;
        #1 chk_reset_outputs("rst_midframe");
        tick();
        chk_reset_outputs("rst_held");
        rst = 1'b1;

        // Thirteen frames: slots 0..11 then back to 0
        for (int f = 0; f < 13; f++) begin
            run_frame(4'(f % 12), 1'b0);
        end
        chk("wrap_last_slot", 64'(a0[14:11]), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_packer.md
# frame_packer

Input stage of the LED panel datapath, directly upstream of the frame RAM that the panel scan controller reads. It accepts a row-major stream of 24-bit RGB pixels for one 64x32 image and folds rows 0-15 and 16-31 into the shared 48-bit word layout, `{upper RGB, lower RGB}`, that the scan controller consumes. It writes into one of `NUM_SLOTS` image slots and advances the slot after each complete frame, filling the slideshow the scan controller cycles through.

## Interface
- `PIXEL_DEPTH`, 8: bits per colour channel.
- `IMG_WIDTH`, 64: pixels per row (log2 fixed at 6).
- `IMG_HEIGHT`, 32: rows per image; upper half is rows 0-15, lower half is rows 16-31.
- `ADDR_WIDTH`, 15: frame RAM word address width.
- `NUM_SLOTS`, 12: number of image slots; the slot index is 4 bits.

- `clk_in`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  pixel beat valid.
- `s_ready`  out  1  packer can accept a beat.
- `s_data`  in  24  pixel `{R[23:16], G[15:8], B[7:0]}`.
- `s_sof`  in  1  start of frame; qualified by `s_valid && s_ready`.
- `wr_en`  out  1  RAM write strobe, one cycle per pixel.
- `wr_addr`  out  15  `{slot[3:0], 1'b0, row[3:0], col[5:0]}`.
- `wr_data`  out  48  `{pix, pix}`; the pixel is replicated into both halves.
- `wr_be`  out  2  half enable: `2'b10` = upper (bits 47:24), `2'b01` = lower (bits 23:0).
- `frame_done`  out  1  one-cycle pulse on the write of the last pixel.
- `sof_err`  out  1  one-cycle pulse when `s_sof` arrives mid-frame.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- **Reset values:** state IDLE; `col`, `row` and `slot` are 0; `s_ready` is 1; `wr_en`, `wr_be`, `frame_done` and `sof_err` are 0; `wr_addr` and `wr_data` are 0.
- **IDLE:**
  - A beat with `s_sof=1` is written as row 0, col 0, and the state moves to RUN.
  - A beat without `s_sof` is accepted and discarded, with no write.
- **RUN:** each accepted beat is written at the current `row`/`col`, then `col` increments.
  - When `col` is 63, `col` wraps to 0 and `row` increments.
  - The beat with `row=31` and `col=63` is the final beat. It moves the state to DONE.
- **Mid-frame `s_sof` in RUN:**
  - `sof_err` pulses.
  - The beat is written as row 0, col 0 of the same slot.
  - The counters restart from that beat, and the slot does not advance.
- **DONE (1 cycle):**
  - `s_ready` is 0.
  - `slot` increments, wrapping from `NUM_SLOTS-1` to 0.
  - `row` and `col` clear, and the state returns to IDLE.
- **Half selection:** `row[4]=0` gives `wr_be=2'b10` with address row field `row[3:0]`. `row[4]=1` gives `wr_be=2'b01`.
- **Address:** `wr_addr[10]` is always 0. Each slot therefore spans 1024 of its 2048 words.
- **Widths:** `col` is 6 bits, `row` is 5 bits, `slot` is 4 bits. Slot values 12-15 are unreachable.

## Timing
- `s_ready` is 1 in IDLE and RUN and 0 only in DONE. It does not depend combinationally on `s_valid`.
- A beat transfers when `s_valid && s_ready` is high at a rising edge.
- Write latency: a beat accepted at edge N appears on `wr_en`/`wr_addr`/`wr_data`/`wr_be` for the cycle after edge N (1 cycle). With `FRAME_PACKER_GAMMA_EN` the latency is 2 cycles.
- `frame_done` and `sof_err` are aligned with the `wr_en` cycle of the beat that caused them.
- Back-to-back throughput is 1 pixel per clock. One full frame is 2048 beats, plus 1 DONE bubble.
- The slot increments on the DONE edge. A final write that is still in flight uses the old slot.
- Reset mid-frame clears immediately: any pending write is dropped, and the slot returns to 0.

## Configuration
- **`FRAME_PACKER_GAMMA_EN` defined:**
  - Each channel c is replaced by `(c*c) >> 8` before packing. An 8x8 multiply is registered as one extra stage.
  - For example 255 maps to 254, 128 maps to 64, and 0 maps to 0.
  - Write latency is 2 cycles. `frame_done` and `sof_err` are delayed to stay aligned with their write.
- **Undefined:** channels pass through unchanged, and latency is 1 cycle.

## Test plan
- **Reset:** `rst=0` asynchronously mid-cycle, then release → all outputs at their reset values, `s_ready=1`, first write goes to slot 0.
- **Full frame, pixel=index:** 2048 beats with `s_sof` on beat 0 →
  - beat 0 writes `wr_addr=0x0000`, `wr_be=10`;
  - beat 1024 (row 16, col 0) writes `wr_addr=0x0000`, `wr_be=01`;
  - beat 2047 writes `wr_addr=0x03FF`, `wr_be=01`, with `frame_done=1`;
  - `s_ready=0` for exactly 1 cycle afterwards.
- **Slot wrap:** 13 consecutive frames → `wr_addr[14:11]` cycles 0..11, and the 13th frame is written to slot 0.
- **Mid-frame resync:** `s_sof` on beat 300 → `sof_err` pulses once; that beat writes `addr 0x0000`, and the frame completes 2047 beats later in the same slot.
- **Discard and stall:** 5 beats without `s_sof` in IDLE, then a frame with random `s_valid` gaps → no writes for the 5 beats; the frame's addresses are contiguous and unaffected by the gaps.
- **Gamma (with macro):** pixel `0xFF8000` → `wr_data` upper half `0xFE4000`, written 2 cycles after acceptance.
